sobel_uart_tx: RTL and testbench
================================

SOBEL_UART_TX -- requirements
Module: sobel_uart_tx

Interface
REQ-001 Parameter CNT_BAUD_END, default 434, clocks per UART bit (115200 baud at 50 MHz sclk); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, byte capacity of the input buffer; power of two, 4..256.
REQ-003 sclk  input  1  single system clock, all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  8  byte to transmit, e.g. a Sobel result pixel.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a byte this cycle.
REQ-008 tx  output  1  UART serial line, idle high.
REQ-009 busy  output  1  high while a frame is in progress or the buffer is non-empty.

Function
REQ-010 A byte SHALL be accepted on a rising edge where in_valid and in_ready are both high; in_valid without in_ready SHALL NOT drop, duplicate or corrupt data.
REQ-011 in_ready SHALL equal NOT full; when the buffer is full, a write SHALL NOT be accepted, even if a read occurs on the same edge.
REQ-012 The buffer SHALL be FIFO ordered; simultaneous write and read SHALL keep the count unchanged; a write to an empty buffer SHALL become readable on the next cycle.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-014 IDLE: tx=1; if the buffer is non-empty, pop one byte into the shift register and enter START.
REQ-015 START: tx=0 for CNT_BAUD_END cycles, then DATA.
REQ-016 DATA: 8 bits LSB first, each for CNT_BAUD_END cycles; a 3-bit index wraps 7->0 on exit to the next state.
REQ-017 STOP: tx=1 for CNT_BAUD_END cycles; on its last cycle, if the buffer is non-empty, pop and enter START directly (no idle gap); otherwise enter IDLE.
REQ-018 Baud counter width SHALL be ceil(log2(CNT_BAUD_END)); it counts 0..CNT_BAUD_END-1 and clears on every bit boundary and in IDLE.
REQ-019 tx SHALL be driven from a flop (glitch-free); tx falls on the second rising edge after the edge that accepts a byte into an empty, idle block.
REQ-020 Frame length SHALL be exactly 10*CNT_BAUD_END cycles (11*CNT_BAUD_END with parity).
REQ-021 busy SHALL be high from the cycle after acceptance until the last STOP cycle of the final buffered byte.

Reset
REQ-022 On rst high: tx=1, busy=0, in_ready=0 while rst is held, FSM=IDLE, counters=0, buffer emptied; all asynchronously.
REQ-023 On rst release: in_ready=1 on the first clock edge; a frame interrupted by reset SHALL NOT resume.

Configuration
REQ-024 Macro SOBEL_UART_TX_PARITY_EN: when defined, PARITY state inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for CNT_BAUD_END cycles; when undefined, no PARITY state and no parity logic exist, and DATA goes straight to STOP.

Structure
REQ-025 Shared package sobel_uart_pkg SHALL hold the FSM state encoding, the default baud constant 434, and the frame bit counts (10/11).
REQ-026 The buffer SHALL be a sub-module sobel_tx_fifo (synchronous FIFO, parameter FIFO_DEPTH, full/empty flags); FSM, baud counter and shifter SHALL live in sobel_uart_tx.

Verification
REQ-027 CNT_BAUD_END=8, write 0xA5 once -> tx = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; busy then falls and tx stays 1.
REQ-028 Write 0x00 and 0xFF back-to-back -> two contiguous 80-cycle frames with no idle cycle between the first STOP and the second START.
REQ-029 FIFO_DEPTH=16, in_valid held high with incrementing data from 0x00 -> exactly 17 bytes accepted before in_ready falls; the bytes are transmitted in order 0x00..0x10 with none lost.
REQ-030 rst pulsed during DATA bit 3 of 0x3C with 3 bytes queued -> tx=1 immediately; busy=0; no further frames; after release, in_ready=1 and a new byte 0x55 is transmitted correctly.
REQ-031 With SOBEL_UART_TX_PARITY_EN and CNT_BAUD_END=8, write 0xA5 -> 88-cycle frame with parity bit 0; write 0x07 -> parity bit 1.
REQ-032 in_valid pulsed while in_ready is low (buffer full) -> byte not accepted; the stream contents are unchanged versus the accepted-byte log.

Source files
------------

// File: rtl/sobel_uart_pkg.sv
// sobel_uart_pkg: FSM state encoding and frame constants shared by the Sobel UART transmitter.
// The PARITY state exists only when SOBEL_UART_TX_PARITY_EN is defined.
package sobel_uart_pkg;
    localparam int DEFAULT_CNT_BAUD_END = 434;
    localparam int FRAME_BITS           = 10;
    localparam int FRAME_BITS_PARITY    = 11;
`ifdef SOBEL_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif
endpackage

// File: rtl/sobel_tx_fifo.sv
// sobel_tx_fifo: synchronous byte FIFO with show-ahead read data and full/empty flags.
module sobel_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_i,
    output logic [7:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          wr_en, rd_en;

    assign wr_en     = wr_i & ~full_o;
    assign rd_en     = rd_i & ~empty_o;
    assign full_o    = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign empty_o   = cnt_q == '0;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
            cnt_q    <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    // Storage needs no reset; emptiness is defined by the count alone.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/sobel_uart_tx.sv
// sobel_uart_tx: buffered 8N1 UART transmitter for Sobel result bytes.
// Define SOBEL_UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module sobel_uart_tx
    import sobel_uart_pkg::*;
#(
    parameter int CNT_BAUD_END = DEFAULT_CNT_BAUD_END,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);
    localparam int             CW       = $clog2(CNT_BAUD_END);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_BAUD_END - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          rdy_q;
    logic          pop, full, empty, bit_end;
    logic [7:0]    fifo_data;

    sobel_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (sclk),
        .rst       (rst),
        .wr_i      (in_valid & in_ready),
        .wr_data_i (in_data),
        .rd_i      (pop),
        .rd_data_o (fifo_data),
        .full_o    (full),
        .empty_o   (empty)
    );

    // rdy_q holds in_ready low until the first edge after reset release.
    assign in_ready = rdy_q & ~full;
    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) | ~empty;
    assign bit_end  = cnt_q == CNT_LAST;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            rdy_q   <= 1'b1;
        end
    end

    // tx_d follows the current state, so the line lags the FSM by one registered cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_data;
                    state_d = START;
                end
            end
            START: begin
                tx_d    = 1'b0;
                state_d = bit_end ? DATA : START;
            end
            DATA: begin
                tx_d = data_q[idx_q];
                if (bit_end) begin
                    idx_d = idx_q + 3'd1;
`ifdef SOBEL_UART_TX_PARITY_EN
                    state_d = (idx_q == 3'd7) ? PARITY : DATA;
`else
                    state_d = (idx_q == 3'd7) ? STOP : DATA;
`endif
                end
            end
`ifdef SOBEL_UART_TX_PARITY_EN
            PARITY: begin
                tx_d    = ^data_q;
                state_d = bit_end ? STOP : PARITY;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    pop     = ~empty;
                    data_d  = empty ? data_q : fifo_data;
                    state_d = empty ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sobel_uart_tx.sv
// tb_sobel_uart_tx: directed bench; a line monitor decodes frames and the main flow
// compares them with the log of accepted bytes.
module tb_sobel_uart_tx;
    import sobel_uart_pkg::*;

    localparam int N = 8;
`ifdef SOBEL_UART_TX_PARITY_EN
    localparam int NB = FRAME_BITS_PARITY;
`else
    localparam int NB = FRAME_BITS;
`endif
    localparam int FL = NB * N;

    logic       sclk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, tx, busy;

    int checks = 0, errors = 0, cyc = 0, shape_err = 0, ci = 0;
    logic [7:0] log_q[$], rx_q[$];
    int         st_q[$];
    logic       par_q[$];

    logic [FL-1:0] ms;
    int            mst;
    bit            mab;
    logic [7:0]    mr;

    sobel_uart_tx #(.CNT_BAUD_END(N), .FIFO_DEPTH(16)) dut (
        .sclk     (sclk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor: samples every cycle of a frame; each bit must be flat for N cycles.
    initial begin
        forever begin
            @(negedge sclk);
            if (!rst && tx === 1'b0) begin
                mst = cyc;
                mab = 1'b0;
                ms = '0;
                ms[0] = tx;
                for (int c = 1; c < FL; c++) begin
                    @(negedge sclk);
                    if (rst) begin
                        mab = 1'b1;
                        break;
                    end
                    ms[c] = tx;
                end
                if (!mab) begin
                    for (int b = 0; b < 8; b++) mr[b] = ms[(b+1)*N + N/2];
                    for (int k = 0; k < NB; k++)
                        for (int j = 0; j < N; j++)
                            if (ms[k*N+j] !== ms[k*N + N/2]) shape_err++;
                    if (ms[N/2] !== 1'b0 || ms[FL - N/2] !== 1'b1) shape_err++;
                    rx_q.push_back(mr);
                    st_q.push_back(mst);
                    par_q.push_back(ms[9*N + N/2]);
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        int w = 0;
        while (in_ready !== 1'b1 && w < 5000) begin
            @(negedge sclk);
            w++;
        end
        chk("push ready", in_ready, 1);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge sclk);
        in_valid = 1'b0;
        log_q.push_back(b);
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while ((rx_q.size() < log_q.size() || busy) && w < 20000) begin
            @(negedge sclk);
            w++;
        end
        repeat (2) @(negedge sclk);
        chk({tag, " count"}, rx_q.size(), log_q.size());
        while (ci < log_q.size() && ci < rx_q.size()) begin
            chk($sformatf("%s byte%0d", tag, ci), rx_q[ci], log_q[ci]);
`ifdef SOBEL_UART_TX_PARITY_EN
            chk($sformatf("%s parity%0d", tag, ci), par_q[ci], ^log_q[ci]);
`endif
            ci++;
        end
        chk({tag, " shape"}, shape_err, 0);
        chk({tag, " idle tx"}, tx, 1);
        chk({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, n, base, lows;
        repeat (3) @(negedge sclk);
        chk("rst tx", tx, 1);
        chk("rst busy", busy, 0);
        chk("rst ready", in_ready, 0);
        rst = 1'b0;
        @(negedge sclk);
        chk("release ready", in_ready, 1);

        push(8'hA5);
        chk("busy after accept", busy, 1);
        lat = 0;
        while (tx === 1'b1 && lat < 10) begin
            @(negedge sclk);
            lat++;
        end
        chk("start latency", lat, 2);
        drain("a5");

        push(8'h00);
        push(8'hFF);
        drain("b2b");
        chk("b2b gap", st_q[2] - st_q[1], FL);

        n = 0;
        in_data  = 8'h00;
        in_valid = 1'b1;
        while (in_ready === 1'b1 && n < 40) begin
            @(negedge sclk);
            log_q.push_back(in_data);
            n++;
            in_data = in_data + 8'd1;
        end
        in_valid = 1'b0;
        chk("burst accepted", n, 17);
        in_data  = 8'hEE;
        in_valid = 1'b1;
        repeat (3) begin
            chk("full ready low", in_ready, 0);
            @(negedge sclk);
        end
        in_valid = 1'b0;
        drain("burst");

        push(8'h07);
        push(8'h80);
        drain("misc");

        base = log_q.size();
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (35) @(negedge sclk);
        chk("pre-rst bit3", tx, 1);
        #1 rst = 1'b1;
        #1;
        chk("async rst tx", tx, 1);
        chk("async rst busy", busy, 0);
        chk("async rst ready", in_ready, 0);
        repeat (3) @(negedge sclk);
        rst = 1'b0;
        @(negedge sclk);
        chk("re-release ready", in_ready, 1);
        lows = 0;
        repeat (3 * FL) begin
            @(negedge sclk);
            if (tx !== 1'b1) lows++;
        end
        chk("no resume lows", lows, 0);
        chk("no resume frames", rx_q.size(), base);
        while (log_q.size() > base) void'(log_q.pop_back());
        push(8'h55);
        drain("post rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
